// File: rtl/morse_key_decoder.sv
// ---------------------------------------------------------------------------
// morse_key_decoder
//   Times key presses on a single Morse key input. Each press is classified
//   as a dot or a dash, and a long release marks the end of a letter. The
//   completed letter is reported as a 3-bit index (A..H = 0..7) that matches
//   the transmitter lookup table.
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   enable        in   1 = decode, 0 = freeze prescaler, FSM and counters
//   key_in        in   raw key, 1 = pressed (asynchronous)
//   key_level     out  synchronized key level (2-cycle latency)
//   busy          out  letter in progress (FSM not IDLE)
//   letter_valid  out  one-cycle pulse when a letter completes
//   letter_index  out  decoded letter 0..7, held until the next pulse
//   letter_known  out  pattern matched A..H, held with the index
//   symbols       out  captured pattern, bit0 = first symbol, 1 = dash
//   symbol_count  out  number of captured symbols (0..4)
// ---------------------------------------------------------------------------
module morse_key_decoder #(
    parameter int TICK_CYCLES      = 6250000,
    parameter int DOT_MAX_TICKS    = 8,
    parameter int LETTER_GAP_TICKS = 12,
    parameter int MAX_SYMBOLS      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       key_in,
    output logic       key_level,
    output logic       busy,
    output logic       letter_valid,
    output logic [2:0] letter_index,
    output logic       letter_known,
    output logic [3:0] symbols,
    output logic [2:0] symbol_count
);

    localparam int               PRESC_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
    localparam logic [7:0]       DOT_MAX_C  = 8'(DOT_MAX_TICKS);
    localparam logic [7:0]       GAP_C      = 8'(LETTER_GAP_TICKS);
    localparam logic [2:0]       MAX_SYM_C  = 3'(MAX_SYMBOLS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 key_meta_q, key_sync_q;
    logic [PRESC_W-1:0]   presc_q;
    logic                 tick;
    logic [7:0]           press_q, press_d;
    logic [7:0]           gap_q, gap_d;
    logic [3:0]           shift_q, shift_d;
    logic [2:0]           count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic [2:0]           index_q, index_d;
    logic                 known_q, known_d;
    logic [3:0]           sym_q, sym_d;
    logic [2:0]           symcnt_q, symcnt_d;
    logic [2:0]           dec_index;
    logic                 dec_known;
    logic [7:0]           press_inc, gap_inc;
    logic                 is_dash;

    // Synchronizer keeps running while disabled so the LED echo stays live;
    // only the timing logic is frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_q <= 1'b0;
            key_sync_q <= 1'b0;
        end else begin
            key_meta_q <= key_in;
            key_sync_q <= key_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else if (enable) begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    assign tick = enable && (presc_q == PRESC_LAST);

    // Saturating tick counters: a key held forever must still read as a dash.
    assign press_inc = (press_q == 8'hFF) ? 8'hFF : press_q + 8'd1;
    assign gap_inc   = (gap_q == 8'hFF) ? 8'hFF : gap_q + 8'd1;
    assign is_dash   = (press_q > DOT_MAX_C);

    // Unused high pattern bits are always zero, so full 4-bit compares are safe.
    always_comb begin
        dec_index = 3'd0;
        dec_known = 1'b0;
        if (!ovf_q) begin
            case (count_q)
                3'd1: if (shift_q == 4'b0000) begin dec_index = 3'd4; dec_known = 1'b1; end
                3'd2: if (shift_q == 4'b0010) begin dec_index = 3'd0; dec_known = 1'b1; end
                3'd3: begin
                    if (shift_q == 4'b0001) begin dec_index = 3'd3; dec_known = 1'b1; end
                    if (shift_q == 4'b0011) begin dec_index = 3'd6; dec_known = 1'b1; end
                end
                3'd4: begin
                    if (shift_q == 4'b0001) begin dec_index = 3'd1; dec_known = 1'b1; end
                    if (shift_q == 4'b0101) begin dec_index = 3'd2; dec_known = 1'b1; end
                    if (shift_q == 4'b0100) begin dec_index = 3'd5; dec_known = 1'b1; end
                    if (shift_q == 4'b0000) begin dec_index = 3'd7; dec_known = 1'b1; end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        press_d  = press_q;
        gap_d    = gap_q;
        shift_d  = shift_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        index_d  = index_q;
        known_d  = known_q;
        sym_d    = sym_q;
        symcnt_d = symcnt_q;
        case (state_q)
            IDLE: begin
                if (tick && key_sync_q) begin
                    state_d = MARK;
                    press_d = 8'd1;
                end
            end
            MARK: begin
                if (tick) begin
                    if (key_sync_q) begin
                        press_d = press_inc;
                    end else begin
                        if (count_q < MAX_SYM_C) begin
                            shift_d[count_q[1:0]] = is_dash;
                            count_d = count_q + 3'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        state_d = SPACE;
                        gap_d   = 8'd1;
                    end
                end
            end
            SPACE: begin
                if (tick) begin
                    if (key_sync_q) begin
                        state_d = MARK;
                        press_d = 8'd1;
                    end else begin
                        gap_d = gap_inc;
                        if (gap_inc >= GAP_C) begin
                            state_d = EMIT;
                        end
                    end
                end
            end
            EMIT: begin
                if (enable) begin
                    valid_d  = 1'b1;
                    index_d  = dec_index;
                    known_d  = dec_known;
                    sym_d    = shift_q;
                    symcnt_d = count_q;
                    shift_d  = 4'd0;
                    count_d  = 3'd0;
                    ovf_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            press_q  <= 8'd0;
            gap_q    <= 8'd0;
            shift_q  <= 4'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            index_q  <= 3'd0;
            known_q  <= 1'b0;
            sym_q    <= 4'd0;
            symcnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            press_q  <= press_d;
            gap_q    <= gap_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            index_q  <= index_d;
            known_q  <= known_d;
            sym_q    <= sym_d;
            symcnt_q <= symcnt_d;
        end
    end

    assign key_level    = key_sync_q;
    assign busy         = (state_q != IDLE);
    assign letter_valid = valid_q;
    assign letter_index = index_q;
    assign letter_known = known_q;
    assign symbols      = sym_q;
    assign symbol_count = symcnt_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_morse_key_decoder
//   Directed bench for morse_key_decoder with TICK_CYCLES=4. Key presses and
//   releases are held for whole multiples of 4 enabled cycles, so each hold
//   spans exactly that many ticks regardless of prescaler phase.
// ---------------------------------------------------------------------------
module tb_morse_key_decoder;

    localparam int TC = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic       key_in = 1'b0;
    logic       key_level;
    logic       busy;
    logic       letter_valid;
    logic [2:0] letter_index;
    logic       letter_known;
    logic [3:0] symbols;
    logic [2:0] symbol_count;

    int vectors = 0;
    int miscompares = 0;
    int pulse_cnt = 0;
    int base_cnt = 0;
    logic [2:0] cap_index;
    logic       cap_known;
    logic [3:0] cap_symbols;
    logic [2:0] cap_count;

    morse_key_decoder #(
        .TICK_CYCLES     (TC),
        .DOT_MAX_TICKS   (8),
        .LETTER_GAP_TICKS(12),
        .MAX_SYMBOLS     (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .key_in      (key_in),
        .key_level   (key_level),
        .busy        (busy),
        .letter_valid(letter_valid),
        .letter_index(letter_index),
        .letter_known(letter_known),
        .symbols     (symbols),
        .symbol_count(symbol_count)
    );

    always #5 clk = ~clk;

    // Capture letter outputs on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (letter_valid) begin
            pulse_cnt   = pulse_cnt + 1;
            cap_index   = letter_index;
            cap_known   = letter_known;
            cap_symbols = symbols;
            cap_count   = symbol_count;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors = vectors + 1;
        if (obs !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int n);
        key_in = 1'b1;
        repeat (TC * n) @(posedge clk);
        #1;
    endtask

    task automatic release_key(input int n);
        key_in = 1'b0;
        repeat (TC * n) @(posedge clk);
        #1;
    endtask

    // Press of (n_before + n_after) enabled ticks with a 100-cycle disable
    // window in between; outputs and busy must not move while frozen.
    task automatic press_gated(input int n_before, input int n_after, input string tag);
        key_in = 1'b1;
        repeat (TC * n_before) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk({tag, "_hold_busy"}, {7'd0, busy}, 8'd1);
        chk({tag, "_hold_count"}, {5'd0, symbol_count}, {5'd0, cap_count});
        repeat (50) @(posedge clk);
        #1;
        chk({tag, "_hold_busy2"}, {7'd0, busy}, 8'd1);
        chk({tag, "_hold_valid"}, {7'd0, letter_valid}, 8'd0);
        enable = 1'b1;
        repeat (TC * n_after) @(posedge clk);
        #1;
    endtask

    task automatic begin_letter();
        base_cnt = pulse_cnt;
    endtask

    // Finish a letter with a 12-tick release plus slack, then check it.
    task automatic end_letter(input string tag, input logic [2:0] idx, input logic known,
                              input logic [3:0] sym, input logic [2:0] cnt);
        release_key(12);
        repeat (16) @(posedge clk);
        #1;
        chk({tag, "_pulses"}, 8'(pulse_cnt - base_cnt), 8'd1);
        chk({tag, "_index"}, {5'd0, cap_index}, {5'd0, idx});
        chk({tag, "_known"}, {7'd0, cap_known}, {7'd0, known});
        chk({tag, "_symbols"}, {4'd0, cap_symbols}, {4'd0, sym});
        chk({tag, "_count"}, {5'd0, cap_count}, {5'd0, cnt});
        chk({tag, "_held_index"}, {5'd0, letter_index}, {5'd0, idx});
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_index"}, {5'd0, letter_index}, 8'd0);
        chk({tag, "_known"}, {7'd0, letter_known}, 8'd0);
        chk({tag, "_symbols"}, {4'd0, symbols}, 8'd0);
        chk({tag, "_count"}, {5'd0, symbol_count}, 8'd0);
        chk({tag, "_valid"}, {7'd0, letter_valid}, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_key_level"}, {7'd0, key_level}, 8'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Letter A: dot (4 ticks), gap 4, dash (12 ticks).
        begin_letter();
        press(4); release_key(4); press(12);
        end_letter("A", 3'd0, 1'b1, 4'b0010, 3'd2);

        // Letter H: four 2-tick dots.
        begin_letter();
        for (int i = 0; i < 4; i++) begin
            press(2);
            if (i < 3) release_key(2);
        end
        end_letter("H", 3'd7, 1'b1, 4'b0000, 3'd4);

        // Letter B: dash, dot, dot, dot.
        begin_letter();
        press(10); release_key(2);
        press(2); release_key(2);
        press(2); release_key(2);
        press(2);
        end_letter("B", 3'd1, 1'b1, 4'b0001, 3'd4);

        // 8-tick press is still a dot -> E; also check synchronizer latency.
        begin_letter();
        key_in = 1'b1;
        @(posedge clk); #1;
        chk("sync_lat1", {7'd0, key_level}, 8'd0);
        @(posedge clk); #1;
        chk("sync_lat2", {7'd0, key_level}, 8'd1);
        repeat (TC * 8 - 2) @(posedge clk);
        #1;
        end_letter("E8", 3'd4, 1'b1, 4'b0000, 3'd1);

        // 11-tick gap keeps the letter open; 9-tick press is a dash -> A.
        begin_letter();
        press(1); release_key(11); press(9);
        end_letter("A_gap11", 3'd0, 1'b1, 4'b0010, 3'd2);

        // A 12-tick gap closes the letter: two separate E letters.
        begin_letter();
        press(1);
        end_letter("E_gap12a", 3'd4, 1'b1, 4'b0000, 3'd1);
        begin_letter();
        press(1);
        end_letter("E_gap12b", 3'd4, 1'b1, 4'b0000, 3'd1);

        // Overflow: five dots.
        begin_letter();
        for (int i = 0; i < 5; i++) begin
            press(1);
            if (i < 4) release_key(2);
        end
        end_letter("ovf", 3'd0, 1'b0, 4'b0000, 3'd4);

        // Enable hold: 6 enabled ticks split by a freeze still reads as a dot.
        begin_letter();
        press_gated(3, 3, "enE");
        end_letter("enE", 3'd4, 1'b1, 4'b0000, 3'd1);

        // Enable hold on a 9-tick dash -> D.
        begin_letter();
        press_gated(4, 5, "enD");
        release_key(2); press(1); release_key(2); press(1);
        end_letter("enD", 3'd3, 1'b1, 4'b0001, 3'd3);

        // Reset mid-SPACE after one dot discards the letter.
        begin_letter();
        press(1); release_key(4);
        chk("midspace_busy", {7'd0, busy}, 8'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("midreset_no_pulse", 8'(pulse_cnt - base_cnt), 8'd0);
        chk("midreset_busy_after", {7'd0, busy}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
Receive-side counterpart of the team's Morse LED transmitter. It times a player's key presses on one input, classifies each press as dot or dash, and detects the inter-letter gap. It then reports the keyed letter as the same 3-bit letter index (A..H = 0..7) used by the transmitter lookup table. The output feeds the game's win/lose compare logic, so players can answer by keying Morse instead of setting switches.

Parameters:
TICK_CYCLES, 6250000, clk cycles per sample tick (8 ticks/s at 50 MHz; sim uses 4)
DOT_MAX_TICKS, 8, press of 1..DOT_MAX_TICKS ticks = dot; longer = dash
LETTER_GAP_TICKS, 12, consecutive released ticks that end a letter
MAX_SYMBOLS, 4, maximum symbols per letter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  1 = decode; 0 = freeze prescaler, FSM and counters
key_in  input  1  raw key, 1 = pressed (asynchronous, e.g. inverted KEY)
key_level  output  1  synchronized key level, for LED echo
busy  output  1  1 while a letter is in progress (FSM not IDLE)
letter_valid  output  1  one-cycle pulse when a letter completes
letter_index  output  3  decoded letter 0..7 (A..H); held until next pulse
letter_known  output  1  1 = symbol pattern matched A..H; held with index
symbols  output  4  captured pattern, bit0 = first symbol, 1 = dash; held
symbol_count  output  3  number of symbols captured (0..4); held

Behaviour:
- Reset (async, reset_n=0): all outputs 0; FSM=IDLE; prescaler, counters, synchronizer and shift state cleared.
- key_in passes through a 2-flop synchronizer. key_level is the second flop, so latency is 2 cycles.
- Prescaler counts 0..TICK_CYCLES-1 while enable=1 and wraps to 0. tick is asserted for the single cycle in which it equals TICK_CYCLES-1. The FSM acts only on tick cycles.
- Tick counters (press and gap) are 8 bits wide and saturate at 255 (no wrap).
- IDLE: on tick with key_level=1, go to MARK with press_cnt=1.
- MARK: on tick with key=1, press_cnt+1 (saturating). On tick with key=0:
  - classify the press as dash if press_cnt>DOT_MAX_TICKS, else dot;
  - shift the symbol into position symbol_count and increment symbol_count;
  - go to SPACE with gap_cnt=1.
- SPACE: on tick with key=1, go to MARK with press_cnt=1. On tick with key=0, gap_cnt+1. When gap_cnt reaches LETTER_GAP_TICKS, go to EMIT.
- Overflow: a 5th symbol sets an internal overflow flag and is not stored; symbol_count stays 4. The letter still ends normally, with letter_known=0.
- EMIT (exactly 1 cycle, independent of tick):
  - assert letter_valid;
  - register symbols, symbol_count, letter_index and letter_known;
  - clear the internal shift state and overflow flag;
  - go to IDLE.
- Decode table as (count, pattern bit3..0):
  - A = (2, 0010) -> 0
  - B = (4, 0001) -> 1
  - C = (4, 0101) -> 2
  - D = (3, 001) -> 3
  - E = (1, 0) -> 4
  - F = (4, 0100) -> 5
  - G = (3, 011) -> 6
  - H = (4, 0000) -> 7
  - Anything else or overflow: letter_known=0 and letter_index=0.
- enable=0: all state holds and no tick is generated. A press or release that occurs while disabled is seen on the first tick after re-enable.
- busy = (FSM != IDLE), combinational from the state register.
- A press held indefinitely stays in MARK with press_cnt saturated at 255. It decodes as a dash on release.
- reset_n asserted mid-letter discards the letter with no letter_valid, and returns outputs to 0.

Test Plan:
TICK_CYCLES=4 for all runs.
- Reset values: pulse reset_n low mid-SPACE after one dot -> all outputs 0, busy=0, no letter_valid afterwards.
- Letter A: press 4 ticks, release 4, press 12, release 12 -> single letter_valid pulse; letter_index=0, letter_known=1, symbols=4'b0010, symbol_count=2.
- Letter H: four 2-tick presses separated by 2-tick gaps, then release 12 -> index=7, known=1, symbols=0000, count=4. Then key B (dash, dot, dot, dot) -> index=1, symbols=0001.
- Boundary: a press of exactly 8 ticks is a dot and 9 ticks is a dash. A gap of 11 ticks followed by a press continues the same letter; a gap of 12 ends it (E emitted for a single dot).
- Overflow: five dots then 12-tick gap -> letter_valid=1, letter_known=0, letter_index=0, symbol_count=4.
- Enable hold: enable=0 for 100 cycles during MARK -> press_cnt, state and outputs unchanged. After re-enable the decode is identical to an uninterrupted press of the same enabled length.
